// File: rtl/rv32_decode_queue.sv
// rtl/rv32_decode_queue.sv - RV32 decode stage with a DEPTH-entry output queue
//
// Decodes raw instruction words from fetch into control fields. The results
// are buffered in a circular queue so fetch can keep running while execute
// stalls.
//
// Optional feature macro: RV32_DECODE_ILLEGAL_TRAP_EN
//   Defined   : dec_illegal flags instructions that do not decode.
//   Undefined : dec_illegal tied 0, and those instructions become NOOPs.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   fetch handshake; in_instr, in_pc carry the word
//   flush               drop all queued entries and any same-cycle input
//   dec_valid/dec_ready execute handshake on the queue head
//   dec_*               decoded fields of the head entry (NOOP when empty)
module rv32_decode_queue #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    input  logic              flush,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [XLEN-1:0]   dec_pc,
    output logic [3:0]        dec_alu_op,
    output logic              dec_alu_alt,
    output logic [1:0]        dec_mem_op,
    output logic [1:0]        dec_mem_size,
    output logic              dec_mem_unsigned,
    output logic              dec_wb_en,
    output logic [REG_AW-1:0] dec_rs1,
    output logic [REG_AW-1:0] dec_rs2,
    output logic [REG_AW-1:0] dec_rd,
    output logic [XLEN-1:0]   dec_imm,
    output logic [2:0]        dec_ctrl,
    output logic [2:0]        dec_br_func,
    output logic              dec_illegal
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [3:0] ALU_NOOP = 4'd8;
    localparam logic [1:0] MEM_LOAD = 2'b00;
    localparam logic [1:0] MEM_STORE = 2'b01;
    localparam logic [1:0] MEM_NOOP = 2'b11;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [3:0]        alu_op;
        logic              alu_alt;
        logic [1:0]        mem_op;
        logic [1:0]        mem_size;
        logic              mem_unsigned;
        logic              wb_en;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   imm;
        logic [2:0]        ctrl;
        logic [2:0]        br_func;
        logic              illegal;
    } entry_t;

    entry_t          dec_now;
    entry_t          head_ent;
    entry_t          noop_ent;
    entry_t          mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic            full;
    logic            push;
    logic            pop;
    logic            illegal;
    logic [31:0]     imm32;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Decode. Anything that does not decode leaves every control field at
    // its NOOP default; only the register index fields are always extracted.
    always_comb begin
        dec_now         = '0;
        dec_now.pc      = in_pc;
        dec_now.alu_op  = ALU_NOOP;
        dec_now.mem_op  = MEM_NOOP;
        dec_now.rs1     = REG_AW'(in_instr[19:15]);
        dec_now.rs2     = REG_AW'(in_instr[24:20]);
        dec_now.rd      = REG_AW'(in_instr[11:7]);
        illegal         = 1'b0;
        imm32           = '0;
        case (opcode)
            7'b0010011: begin
                dec_now.alu_op  = {1'b0, funct3};
                dec_now.alu_alt = (funct3 == 3'b101) & in_instr[30];
                dec_now.wb_en   = 1'b1;
                imm32           = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0110011: begin
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    dec_now.alu_op  = {1'b0, funct3};
                    dec_now.alu_alt = in_instr[30];
                    dec_now.wb_en   = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            7'b0000011: begin
                if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
                    funct3 == 3'b100 || funct3 == 3'b101) begin
                    dec_now.alu_op       = 4'd0;
                    dec_now.mem_op       = MEM_LOAD;
                    dec_now.mem_size     = funct3[1:0];
                    dec_now.mem_unsigned = funct3[2];
                    dec_now.wb_en        = 1'b1;
                    imm32                = {{20{in_instr[31]}}, in_instr[31:20]};
                end else begin
                    illegal = 1'b1;
                end
            end
            7'b0100011: begin
                if (funct3 <= 3'b010) begin
                    dec_now.alu_op   = 4'd0;
                    dec_now.mem_op   = MEM_STORE;
                    dec_now.mem_size = funct3[1:0];
                    imm32            = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                end else begin
                    illegal = 1'b1;
                end
            end
            7'b1100011: begin
                if (funct3 != 3'b010 && funct3 != 3'b011) begin
                    dec_now.ctrl    = 3'd1;
                    dec_now.br_func = funct3;
                    imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                             in_instr[11:8], 1'b0};
                end else begin
                    illegal = 1'b1;
                end
            end
            7'b1101111: begin
                dec_now.ctrl  = 3'd2;
                dec_now.wb_en = 1'b1;
                imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                         in_instr[30:21], 1'b0};
            end
            7'b1100111: begin
                if (funct3 == 3'b000) begin
                    dec_now.ctrl  = 3'd3;
                    dec_now.wb_en = 1'b1;
                    imm32         = {{20{in_instr[31]}}, in_instr[31:20]};
                end else begin
                    illegal = 1'b1;
                end
            end
            7'b0110111: begin
                dec_now.ctrl  = 3'd4;
                dec_now.wb_en = 1'b1;
                imm32         = {in_instr[31:12], 12'b0};
            end
            7'b0010111: begin
                dec_now.ctrl  = 3'd5;
                dec_now.wb_en = 1'b1;
                imm32         = {in_instr[31:12], 12'b0};
            end
            7'b0001111, 7'b1110011: begin
                // FENCE and SYSTEM have no effect in this core
            end
            default: illegal = 1'b1; // also catches instr[1:0] != 2'b11
        endcase
        dec_now.imm = XLEN'($signed(imm32));
        if (in_instr[11:7] == 5'd0) begin
            dec_now.wb_en = 1'b0;
        end
`ifdef RV32_DECODE_ILLEGAL_TRAP_EN
        dec_now.illegal = illegal;
`else
        // Flag tied low; the instruction already decoded as a NOOP above.
        dec_now.illegal = illegal & 1'b0;
`endif
    end

    always_comb begin
        noop_ent        = '0;
        noop_ent.alu_op = ALU_NOOP;
        noop_ent.mem_op = MEM_NOOP;
    end

    assign full      = (count == CW'(DEPTH));
    assign dec_valid = (count != '0);
    // A full queue can still accept when the head leaves in the same cycle.
    assign in_ready  = !full || dec_ready;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = dec_valid && dec_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage needs no reset: it is only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= dec_now;
        end
    end

    assign head_ent = dec_valid ? mem[head] : noop_ent;

    assign dec_pc           = head_ent.pc;
    assign dec_alu_op       = head_ent.alu_op;
    assign dec_alu_alt      = head_ent.alu_alt;
    assign dec_mem_op       = head_ent.mem_op;
    assign dec_mem_size     = head_ent.mem_size;
    assign dec_mem_unsigned = head_ent.mem_unsigned;
    assign dec_wb_en        = head_ent.wb_en;
    assign dec_rs1          = head_ent.rs1;
    assign dec_rs2          = head_ent.rs2;
    assign dec_rd           = head_ent.rd;
    assign dec_imm          = head_ent.imm;
    assign dec_ctrl         = head_ent.ctrl;
    assign dec_br_func      = head_ent.br_func;
    assign dec_illegal      = head_ent.illegal;

endmodule

// File: tb/tb_rv32_decode_queue.sv
// tb/tb_rv32_decode_queue.sv - directed self-checking bench for rv32_decode_queue
module tb_rv32_decode_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [3:0]  dec_alu_op;
    logic        dec_alu_alt;
    logic [1:0]  dec_mem_op;
    logic [1:0]  dec_mem_size;
    logic        dec_mem_unsigned;
    logic        dec_wb_en;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic [31:0] dec_imm;
    logic [2:0]  dec_ctrl;
    logic [2:0]  dec_br_func;
    logic        dec_illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rv32_decode_queue #(.XLEN(32), .REG_AW(5), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
        .dec_alu_op(dec_alu_op), .dec_alu_alt(dec_alu_alt),
        .dec_mem_op(dec_mem_op), .dec_mem_size(dec_mem_size),
        .dec_mem_unsigned(dec_mem_unsigned), .dec_wb_en(dec_wb_en),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_imm(dec_imm), .dec_ctrl(dec_ctrl), .dec_br_func(dec_br_func),
        .dec_illegal(dec_illegal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        step();
        in_valid = 1'b0;
        #1;
    endtask

    task automatic pop_one();
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; dec_ready = 1'b0;
        step(); step();
        check("rst_valid", dec_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_alu_op", dec_alu_op, 8);
        check("rst_mem_op", dec_mem_op, 3);
        check("rst_wb_en", dec_wb_en, 0);
        check("rst_ctrl", dec_ctrl, 0);
        check("rst_imm", dec_imm, 0);
        check("rst_pc", dec_pc, 0);
        check("rst_rd", dec_rd, 0);
        check("rst_illegal", dec_illegal, 0);
        rst = 1'b0;
        step();

        // addi x1,x2,-1: no same-cycle bypass, visible one cycle later
        in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h100;
        #1;
        check("addi_no_bypass", dec_valid, 0);
        step();
        in_valid = 1'b0;
        #1;
        check("addi_valid", dec_valid, 1);
        check("addi_alu_op", dec_alu_op, 0);
        check("addi_alt", dec_alu_alt, 0);
        check("addi_rd", dec_rd, 1);
        check("addi_rs1", dec_rs1, 2);
        check("addi_imm", dec_imm, 32'hFFFFFFFF);
        check("addi_wb", dec_wb_en, 1);
        check("addi_pc", dec_pc, 32'h100);
        check("addi_mem_op", dec_mem_op, 3);
        pop_one();
        check("addi_popped", dec_valid, 0);

        // srai x1,x2,3
        push_one(32'h40315093, 32'h104);
        check("srai_alu_op", dec_alu_op, 5);
        check("srai_alt", dec_alu_alt, 1);
        check("srai_shamt", dec_imm[4:0], 3);
        check("srai_wb", dec_wb_en, 1);
        pop_one();

        // sub x0,x1,x2: rd=0 suppresses writeback
        push_one(32'h40208033, 32'h108);
        check("sub_alu_op", dec_alu_op, 0);
        check("sub_alt", dec_alu_alt, 1);
        check("sub_wb", dec_wb_en, 0);
        check("sub_rs1", dec_rs1, 1);
        check("sub_rs2", dec_rs2, 2);
        pop_one();

        // fill the queue while execute stalls
        push_one(32'h00100093, 32'h200);  // addi x1,x0,1
        check("fill1_in_ready", in_ready, 1);
        push_one(32'h00200113, 32'h204);  // addi x2,x0,2
        check("full_in_ready", in_ready, 0);
        check("full_head_pc", dec_pc, 32'h200);
        in_valid = 1'b1; in_instr = 32'h00300193; in_pc = 32'h208;  // addi x3,x0,3
        step();
        check("full_hold_pc", dec_pc, 32'h200);
        check("full_hold_imm", dec_imm, 1);
        check("full_hold_ready", in_ready, 0);
        dec_ready = 1'b1;
        #1;
        check("full_pop_in_ready", in_ready, 1);
        step();
        dec_ready = 1'b0; in_valid = 1'b0;
        #1;
        check("swap_head_pc", dec_pc, 32'h204);
        check("swap_head_imm", dec_imm, 2);
        check("swap_still_full", in_ready, 0);
        pop_one();
        check("swap_tail_pc", dec_pc, 32'h208);
        check("swap_tail_rd", dec_rd, 3);
        pop_one();
        check("swap_drained", dec_valid, 0);

        // lhu x5,-2(x6)
        push_one(32'hFFE35283, 32'h300);
        check("lhu_mem_op", dec_mem_op, 0);
        check("lhu_size", dec_mem_size, 1);
        check("lhu_unsigned", dec_mem_unsigned, 1);
        check("lhu_imm", dec_imm, 32'hFFFFFFFE);
        check("lhu_wb", dec_wb_en, 1);
        check("lhu_alu_op", dec_alu_op, 0);
        pop_one();

        // sw x5,4(x2)
        push_one(32'h00512223, 32'h304);
        check("sw_mem_op", dec_mem_op, 1);
        check("sw_size", dec_mem_size, 2);
        check("sw_imm", dec_imm, 4);
        check("sw_wb", dec_wb_en, 0);
        check("sw_rs2", dec_rs2, 5);
        pop_one();

        // beq x1,x2,+8 and lui x1,0x12345
        push_one(32'h00208463, 32'h308);
        check("beq_ctrl", dec_ctrl, 1);
        check("beq_br_func", dec_br_func, 0);
        check("beq_imm", dec_imm, 8);
        check("beq_wb", dec_wb_en, 0);
        pop_one();
        push_one(32'h123450B7, 32'h30C);
        check("lui_ctrl", dec_ctrl, 4);
        check("lui_imm", dec_imm, 32'h12345000);
        check("lui_wb", dec_wb_en, 1);
        pop_one();

        // flush beats a same-cycle push and pop
        push_one(32'h00100093, 32'h400);
        push_one(32'h00200113, 32'h404);
        in_valid = 1'b1; in_instr = 32'h00300193; in_pc = 32'h408;
        dec_ready = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; dec_ready = 1'b0; flush = 1'b0;
        #1;
        check("flush_valid", dec_valid, 0);
        check("flush_in_ready", in_ready, 1);
        step();
        check("flush_stays_empty", dec_valid, 0);
        push_one(32'h00500293, 32'h500);  // addi x5,x0,5
        check("post_flush_pc", dec_pc, 32'h500);
        check("post_flush_imm", dec_imm, 5);
        pop_one();
        check("post_flush_drained", dec_valid, 0);

        // unknown opcode decodes as NOOP
        push_one(32'h0000007F, 32'h600);
        check("ill_valid", dec_valid, 1);
        check("ill_alu_op", dec_alu_op, 8);
        check("ill_mem_op", dec_mem_op, 3);
        check("ill_wb", dec_wb_en, 0);
        check("ill_ctrl", dec_ctrl, 0);
`ifdef RV32_DECODE_ILLEGAL_TRAP_EN
        check("ill_flag", dec_illegal, 1);
`else
        check("ill_flag", dec_illegal, 0);
`endif
        pop_one();

        // asynchronous reset empties the queue without a clock edge
        push_one(32'h00100093, 32'h700);
        check("arst_pre_valid", dec_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_valid", dec_valid, 0);
        check("arst_pc", dec_pc, 0);
        step();
        rst = 1'b0;
        step();
        check("arst_after_valid", dec_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32_decode_queue.md
Name: rv32_decode_queue

Overview:
- Parametrised decode stage for the multicycle RV32 core, sitting between the fetch and execute stages.
- Accepts raw instruction words and PCs over a valid/ready handshake and decodes them into control fields: ALU op, memory op/size, writeback enable, immediate, register indices and control-flow class.
- Results are buffered in a DEPTH-entry output queue so fetch keeps running while execute stalls.
- Supports a flush for redirects.

Parameters:
XLEN, 32, datapath width; immediates sign-extended to XLEN (must be >= 32)
REG_AW, 5, register index width; fields taken from the standard bit positions, zero-extended when REG_AW > 5
DEPTH, 2, output queue entries (>= 1; power of two not required)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  decode can accept; equals (queue not full) OR (dec_ready AND queue full)
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction PC
flush  in  1  discard all queued entries and any same-cycle input
dec_valid  out  1  head entry valid
dec_ready  in  1  execute consumes the head entry
dec_pc  out  XLEN  PC of the head entry
dec_alu_op  out  4  ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SRL=5, OR=6, AND=7, ALU_NOOP=8
dec_alu_alt  out  1  SUB for ADD, SRA for SRL
dec_mem_op  out  2  LOAD=00, STORE=01, MEM_NOOP=11
dec_mem_size  out  2  BYTE=00, HALF_WORD=01, WORD=10
dec_mem_unsigned  out  1  LBU/LHU
dec_wb_en  out  1  write rd
dec_rs1, dec_rs2, dec_rd  out  REG_AW  register indices
dec_imm  out  XLEN  sign-extended immediate
dec_ctrl  out  3  0 none, 1 branch, 2 JAL, 3 JALR, 4 LUI, 5 AUIPC
dec_br_func  out  3  funct3 for branches
dec_illegal  out  1  illegal instruction (see Optional Feature)

Behaviour:
- Reset: queue empty; dec_valid=0; in_ready=1. Head-entry outputs read as a NOOP: alu_op=ALU_NOOP, mem_op=MEM_NOOP, wb_en=0, ctrl=0, imm=0, indices=0, pc=0, illegal=0.
- Accept occurs on in_valid && in_ready. Decode is combinational; the result is written into the queue tail at the clock edge.
  - Latency: dec_valid rises the cycle after the first accept into an empty queue. There is no same-cycle bypass.
- Pop occurs on dec_valid && dec_ready. Outputs must hold stable while dec_valid=1 and dec_ready=0.
- Queue:
  - Circular buffer; head/tail wrap at DEPTH; occupancy count 0..DEPTH.
  - Simultaneous push and pop keeps the count unchanged, including when full (in_ready=1 when full and dec_ready=1).
  - Push when full without a pop is impossible by construction.
- Flush has priority over everything:
  - Count becomes 0 on the next edge.
  - Any same-cycle accept or pop is ignored.
  - dec_valid=0 in the following cycle.
- Decode rules:
  - I-type (0010011): alu_op from funct3; alu_alt=instr[30] only for funct3=101; wb_en=1; imm=I.
  - R-type (0110011): alu_op from funct3; alu_alt=instr[30] for 000/101; wb_en=1.
  - Load (0000011): alu ADD, mem LOAD, size/unsigned from funct3, wb_en=1.
  - Store (0100011): alu ADD, mem STORE, size from funct3, imm=S, wb_en=0.
  - Branch (1100011): ctrl=1, br_func=funct3, imm=B, wb_en=0.
  - JAL: ctrl=2, imm=J, wb_en=1.
  - JALR: ctrl=3, imm=I, wb_en=1.
  - LUI: ctrl=4, imm=U.
  - AUIPC: ctrl=5, imm=U. Both LUI and AUIPC write back.
  - FENCE (0001111) / SYSTEM (1110011): treated as NOOP, wb_en=0.
- rd=0 forces wb_en=0.
- Unlisted opcodes, and unused funct3 codes for load/store/branch, decode as NOOP (all control off).
- Reset asserted mid-operation empties the queue immediately (asynchronous); no pop is reported.

Optional Feature:
- Macro RV32_DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - dec_illegal=1 for unknown opcodes, bad funct3 on load/store/branch/JALR, instr[1:0]!=11, and R-type funct7 not in {0000000, 0100000} (0100000 only with funct3 000/101).
  - Control fields are still forced to NOOP; the entry still flows through the queue in order.
- Undefined: dec_illegal tied 0 and those instructions silently become NOOPs.

Test Plan:
- Reset, then push 0xFFF10093 (addi x1,x2,-1) at pc 0x100 -> next cycle dec_valid=1, alu_op=0, alu_alt=0, rd=1, rs1=2, imm=0xFFFFFFFF, wb_en=1, pc=0x100.
- Push 0x40315093 (srai x1,x2,3) -> alu_op=5, alu_alt=1, imm[4:0]=3; push 0x40208033 (sub x0,x1,x2) -> alu_op=0, alu_alt=1, wb_en=0.
- Hold dec_ready=0 and push 3 instructions with DEPTH=2 -> in_ready=0 after 2 accepts, head unchanged; then dec_ready=1 for 1 cycle with in_valid=1 -> one pop and one push, count stays 2, order preserved.
- Push lhu x5,-2(x6) (0xFFE35283) -> mem_op=00, size=01, unsigned=1; push sw (0x00512223) -> mem_op=01, size=10, imm=4, wb_en=0.
- With 2 entries queued, assert flush together with in_valid and dec_ready -> next cycle dec_valid=0, count 0, flushed instruction never appears.
- Macro defined, push 0x0000007F -> dec_illegal=1, alu_op=8, mem_op=11; macro undefined -> dec_illegal=0, same NOOP fields.
